// File: rtl/alu_responder_if.sv
// Operand/opcode request channel and result response channel between the
// system controller (master) and the ALU responder (slave).
interface alu_responder_if #(
  parameter int WIDTH = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_op;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_cf;
  logic             rsp_sf;
  logic             rsp_zf;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_cf, rsp_sf, rsp_zf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_cf, rsp_sf, rsp_zf
  );
endinterface

// File: rtl/alu_responder.sv
// One-stage add/subtract ALU responder with an in-order result FIFO.
// Acceptance is credit based so the stage never stalls and the FIFO never overflows.
module alu_responder #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  alu_responder_if.slave   bus,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = WIDTH + 3;

  typedef logic [ENT_W-1:0] entry_t;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_op_q, s1_op_d;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [WIDTH:0]   wide_res;
  logic [WIDTH-1:0] res;
  logic             res_cf;
  logic             res_sf;
  logic             res_zf;
  entry_t           s1_entry;
  entry_t           head;
  logic [PTR_W+1:0] credits_used;
  logic             req_ready_w;
  logic             rsp_valid_w;
  logic             accept;
  logic             push;
  logic             pop;

  // The extra top bit of the widened difference is exactly the unsigned borrow.
  always_comb begin
    wide_res = '0;
    if (s1_op_q) begin
      wide_res = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    end else begin
      wide_res = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    end
    res      = wide_res[WIDTH-1:0];
    res_cf   = wide_res[WIDTH];
    res_sf   = res[WIDTH-1];
    res_zf   = (res == '0);
    s1_entry = {res, res_cf, res_sf, res_zf};
  end

  always_comb begin
    credits_used = {1'b0, count_q} + {{(PTR_W+1){1'b0}}, s1_valid_q};
    req_ready_w  = (credits_used < (PTR_W+2)'(DEPTH));
    rsp_valid_w  = (count_q != '0);
    accept       = bus.req_valid && req_ready_w;
    push         = s1_valid_q;
    pop          = rsp_valid_w && bus.rsp_ready;
    head         = mem_q[rd_ptr_q];
  end

  assign bus.req_ready  = req_ready_w;
  assign bus.rsp_valid  = rsp_valid_w;
  assign bus.rsp_result = rsp_valid_w ? head[ENT_W-1:3] : '0;
  assign bus.rsp_cf     = rsp_valid_w && head[2];
  assign bus.rsp_sf     = rsp_valid_w && head[1];
  assign bus.rsp_zf     = rsp_valid_w && head[0];
  assign busy           = s1_valid_q || rsp_valid_w;
  assign op_count       = op_count_q;

  always_comb begin
    s1_valid_d = accept;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    if (accept) begin
      s1_a_d  = bus.req_a;
      s1_b_d  = bus.req_b;
      s1_op_d = bus.req_op;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    op_count_d = op_count_q;
    if (push) begin
      mem_d[wr_ptr_q] = s1_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      op_count_d = op_count_q + CNT_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      op_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      op_count_q <= op_count_d;
    end
  end

  // Storage needs no reset: entries are only visible once count_q covers them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_alu_responder.sv
// Self-checking bench for alu_responder: directed vector table, backpressure,
// push/pop, mid-operation reset and counter wrap, all tracked by a queue model.
module tb_alu_responder;

  localparam int WIDTH = 5;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int MOD   = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             reset;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  alu_responder_if #(.WIDTH(WIDTH)) bus ();

  alu_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int result;
    int cf;
    int sf;
    int zf;
  } rsp_t;

  typedef struct {
    int a;
    int b;
    int op;
    int result;
    int cf;
    int sf;
    int zf;
  } vec_t;

  rsp_t m_fifo [$];
  rsp_t m_stage;
  bit   m_stage_valid;
  int   m_pops;
  int   n_checks;
  int   n_fail;
  int   dut_accepts;
  int   guard;
  vec_t vecs [8];

  function automatic rsp_t model_op(int a, int b, int op);
    rsp_t r;
    int   raw;
    if (op == 0) begin
      raw  = a + b;
      r.cf = (raw >= MOD) ? 1 : 0;
    end else begin
      raw  = a - b;
      r.cf = (a < b) ? 1 : 0;
    end
    r.result = (raw + 2 * MOD) % MOD;
    r.sf     = (r.result >= MOD / 2) ? 1 : 0;
    r.zf     = (r.result == 0) ? 1 : 0;
    return r;
  endfunction

  function automatic int model_ready();
    return ((m_fifo.size() + int'(m_stage_valid)) < DEPTH) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    int nonempty;
    nonempty = (m_fifo.size() != 0) ? 1 : 0;
    check("req_ready", int'(bus.req_ready), model_ready());
    check("rsp_valid", int'(bus.rsp_valid), nonempty);
    if (nonempty != 0) begin
      check("rsp_result", int'(bus.rsp_result), m_fifo[0].result);
      check("rsp_cf", int'(bus.rsp_cf), m_fifo[0].cf);
      check("rsp_sf", int'(bus.rsp_sf), m_fifo[0].sf);
      check("rsp_zf", int'(bus.rsp_zf), m_fifo[0].zf);
    end
    check("busy", int'(busy), (m_stage_valid || nonempty != 0) ? 1 : 0);
    check("op_count", int'(op_count), m_pops % (1 << CNT_W));
  endtask

  // One clock cycle: drive, check the pre-edge state, advance the model at the edge.
  task automatic applyStimulus(input bit v, input int a, input int b, input bit op, input bit rr);
    bit acc;
    bit pop;
    bus.req_valid = v;
    bus.req_a     = WIDTH'(a);
    bus.req_b     = WIDTH'(b);
    bus.req_op    = op;
    bus.rsp_ready = rr;
    #1;
    checkOutput();
    if (v && bus.req_ready) dut_accepts++;
    acc = v && (model_ready() != 0);
    pop = rr && (m_fifo.size() != 0);
    @(posedge clk);
    if (pop) begin
      m_fifo.delete(0);
      m_pops++;
    end
    if (m_stage_valid) m_fifo.push_back(m_stage);
    m_stage_valid = acc;
    if (acc) m_stage = model_op(a % MOD, b % MOD, int'(op));
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_op_count"}, int'(op_count), 0);
    check({tag, "_req_ready"}, int'(bus.req_ready), 1);
    check({tag, "_rsp_result"}, int'(bus.rsp_result), 0);
  endtask

  task automatic clear_model();
    m_fifo.delete();
    m_stage_valid = 1'b0;
    m_pops        = 0;
  endtask

  task automatic drain(input string tag);
    guard = 0;
    while ((m_stage_valid || m_fifo.size() != 0) && guard < 40) begin
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
      guard++;
    end
    check({tag, "_drained"}, int'(busy), 0);
  endtask

  function automatic int rnd_op();
    return int'($urandom_range(MOD - 1, 0));
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    dut_accepts = 0;
    clear_model();
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = 1'b0;
    bus.rsp_ready = 1'b0;

    vecs[0] = '{9, 7, 0, 16, 0, 1, 0};
    vecs[1] = '{31, 1, 0, 0, 1, 0, 1};
    vecs[2] = '{3, 5, 1, 30, 1, 1, 0};
    vecs[3] = '{0, 0, 1, 0, 0, 0, 1};
    vecs[4] = '{15, 16, 0, 31, 0, 1, 0};
    vecs[5] = '{20, 20, 1, 0, 0, 0, 1};
    vecs[6] = '{16, 16, 0, 0, 1, 0, 1};
    vecs[7] = '{17, 3, 1, 14, 0, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors, issued at the first edge after release, with 2-cycle latency.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].op[0], 1'b0);
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
      #1;
      check("vec_rsp_valid", int'(bus.rsp_valid), 1);
      check("vec_result", int'(bus.rsp_result), vecs[i].result);
      check("vec_cf", int'(bus.rsp_cf), vecs[i].cf);
      check("vec_sf", int'(bus.rsp_sf), vecs[i].sf);
      check("vec_zf", int'(bus.rsp_zf), vecs[i].zf);
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
      check("vec_op_count", int'(op_count), i + 1);
    end

    // Backpressure: six back-to-back requests, only DEPTH fit.
    dut_accepts = 0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, rnd_op(), rnd_op(), 1'($urandom_range(1, 0)), 1'b0);
    check("bp_accepts", dut_accepts, DEPTH);
    check("bp_ready_low", int'(bus.req_ready), 0);
    dut_accepts = 0;
    guard = 0;
    while ((dut_accepts < 2 || m_stage_valid || m_fifo.size() != 0) && guard < 40) begin
      applyStimulus(dut_accepts < 2, rnd_op(), rnd_op(), 1'($urandom_range(1, 0)), 1'b1);
      guard++;
    end
    check("bp_extra_accepts", dut_accepts, 2);
    check("bp_drained", int'(busy), 0);

    // Two in the FIFO plus one in the stage, then steady push+pop across pointer wrap.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, rnd_op(), rnd_op(), 1'($urandom_range(1, 0)), 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, rnd_op(), rnd_op(), 1'($urandom_range(1, 0)), 1'b1);
      check("pp_fifo_level", m_fifo.size(), 2);
    end
    drain("pp");

    // Reset with one result in the stage and three in the FIFO.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, rnd_op(), rnd_op(), 1'($urandom_range(1, 0)), 1'b0);
    check("pre_reset_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    check_reset_state("midreset");
    clear_model();
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 9, 7, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    #1;
    check("post_reset_valid", int'(bus.rsp_valid), 1);
    check("post_reset_result", int'(bus.rsp_result), 16);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    check("post_reset_op_count", int'(op_count), 1);
    check("post_reset_idle", int'(busy), 0);

    // Random traffic against the model.
    for (int i = 0; i < 200; i++) begin
      applyStimulus($urandom_range(9, 0) < 7, rnd_op(), rnd_op(),
                    1'($urandom_range(1, 0)), $urandom_range(9, 0) < 6);
    end
    drain("rand");

    // Stream until 256 responses have completed since reset; counter must wrap to 0.
    guard = 0;
    while (m_pops < 256 && guard < 3000) begin
      applyStimulus(1'b1, rnd_op(), rnd_op(), 1'($urandom_range(1, 0)), 1'b1);
      guard++;
    end
    check("wrap_reached", m_pops, 256);
    check("op_count_wrap", int'(op_count), 0);
    drain("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
